prng_sponge: RTL and testbench

Parametrised sponge-based pseudo-random generator for the ROLLO RNG path. It loads a seed, either caller-supplied or all-zero, into a 200-bit Keccak-f[200] state. It then squeezes an arbitrary number of OUT_W-bit words, re-permuting the state each time the rate portion is exhausted. Downstream sampling logic (error/secret vector generation) consumes the words through a valid/ack handshake with backpressure.

---
 rtl/prng_sponge_pkg.sv | 43 ++++
 rtl/prng_sponge_if.sv | 35 +++
 rtl/prng_sponge_round.sv | 54 +++++
 rtl/prng_sponge.sv | 135 +++++++++++++
 tb/tb_prng_sponge.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/prng_sponge_pkg.sv
// -----------------------------------------------------------------------------
// prng_pkg
// Shared constants for the sponge PRNG: Keccak-f[200] state geometry, the
// 18 round constants (low byte of the standard Keccak RC values), the rho
// rotation amounts reduced mod 8, the FSM state encoding and the 8-bit lane
// rotate helper.
// No ports (package).
// -----------------------------------------------------------------------------
package prng_pkg;

    localparam int STATE_W = 200;
    localparam int NROUNDS = 18;

    typedef logic [7:0] lane_t;

    // FSM encoding kept as plain constants so older tools can consume it.
    typedef logic [1:0] fsm_t;
    localparam fsm_t ST_IDLE    = 2'd0;
    localparam fsm_t ST_PERMUTE = 2'd1;
    localparam fsm_t ST_SQUEEZE = 2'd2;

    localparam lane_t RC [NROUNDS] = '{
        8'h01, 8'h82, 8'h8a, 8'h00, 8'h8b, 8'h01, 8'h81, 8'h09, 8'h8a,
        8'h88, 8'h09, 8'h0a, 8'h8b, 8'h8b, 8'h89, 8'h03, 8'h02, 8'h80
    };

    // Indexed by lane number 5*y + x.
    localparam int unsigned RHO [25] = '{
        0, 1, 6, 4, 3,
        4, 4, 6, 7, 4,
        3, 2, 3, 1, 7,
        1, 5, 7, 5, 0,
        2, 2, 5, 0, 6
    };

    // Rotate towards the MSB; lane bit z lives at lane bit position z.
    function automatic lane_t rotl8(input lane_t v, input int unsigned r);
        logic [15:0] w;
        w = {v, v} << r;
        return w[15:8];
    endfunction

endpackage

// File: rtl/prng_sponge_if.sv
// -----------------------------------------------------------------------------
// prng_sponge_if
// Request / output-word handshake bundle of the sponge PRNG.
//   in_ready  : request strobe          in_seed  : caller seed
//   in_mod    : 1 = use in_seed         in_nwords: words to emit
//   out_rng   : current output word     out_ready: out_rng valid
//   out_ack   : consumer takes word     busy     : request in progress
//   done      : one-cycle completion pulse
// master = requester/consumer side, slave = generator side.
// -----------------------------------------------------------------------------
interface prng_sponge_if #(
    parameter int SEED_W = 96,
    parameter int OUT_W  = 32,
    parameter int CNT_W  = 16
);
    logic              in_ready;
    logic [SEED_W-1:0] in_seed;
    logic              in_mod;
    logic [CNT_W-1:0]  in_nwords;
    logic [OUT_W-1:0]  out_rng;
    logic              out_ready;
    logic              out_ack;
    logic              busy;
    logic              done;

    modport master (
        output in_ready, in_seed, in_mod, in_nwords, out_ack,
        input  out_rng, out_ready, busy, done
    );

    modport slave (
        input  in_ready, in_seed, in_mod, in_nwords, out_ack,
        output out_rng, out_ready, busy, done
    );
endinterface

// File: rtl/prng_sponge_round.sv
// -----------------------------------------------------------------------------
// keccak_f200_round
// One combinational Keccak-f[200] round: theta, rho, pi, chi, iota.
//   state      : current 200-bit state, lane i at state[199-8i -: 8]
//   round      : round index 0..17 (selects the iota constant)
//   state_next : state after the round
// -----------------------------------------------------------------------------
module keccak_f200_round
    import prng_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic [4:0]         round,
    output logic [STATE_W-1:0] state_next
);

    lane_t a [25];
    lane_t b [25];
    lane_t e [25];
    lane_t c [5];
    lane_t d [5];

    always_comb begin
        // NOTE: every variable gets a default before any conditional or
        // indexed write, so no path can leave it unassigned and infer a latch.
        a          = '{default: '0};
        b          = '{default: '0};
        e          = '{default: '0};
        c          = '{default: '0};
        d          = '{default: '0};
        state_next = '0;

        for (int i = 0; i < 25; i++) a[i] = state[STATE_W-1-8*i -: 8];

        // theta: column parities folded back into every lane
        for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
        for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rotl8(c[(x+1)%5], 1);

        // rho + pi: lane (x,y) rotated, then moved to (y, 2x+3y)
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                b[5*((2*x+3*y)%5) + y] = rotl8(a[5*y+x] ^ d[x], RHO[5*y+x]);

        // chi: row-wise non-linear mix
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                e[5*y+x] = b[5*y+x] ^ (~b[5*y+(x+1)%5] & b[5*y+(x+2)%5]);

        // iota
        e[0] = e[0] ^ RC[round];

        for (int i = 0; i < 25; i++) state_next[STATE_W-1-8*i -: 8] = e[i];
    end

endmodule

// File: rtl/prng_sponge.sv
// -----------------------------------------------------------------------------
// prng_sponge
// Sponge PRNG over Keccak-f[200]: loads a seed (or zeros), permutes for 18
// cycles, then squeezes OUT_W-bit words from the top RATE bits, re-permuting
// the whole state whenever the rate is used up.
//   clk   : clock
//   rst_b : asynchronous active-low reset
//   bus   : prng_sponge_if slave (request, output word handshake, status)
// -----------------------------------------------------------------------------
module prng_sponge
    import prng_pkg::*;
#(
    parameter int SEED_W = 96,
    parameter int RATE   = 96,
    parameter int OUT_W  = 32,
    parameter int CNT_W  = 16
)(
    input logic           clk,
    input logic           rst_b,
    prng_sponge_if.slave  bus
);

    localparam int         WORDS      = RATE / OUT_W;
    localparam int         K_W        = $clog2(WORDS) + 1;
    localparam logic [4:0] LAST_ROUND = 5'(NROUNDS - 1);

    fsm_t               fsm_q, fsm_d;
    logic [STATE_W-1:0] state_q, state_d, round_out, seed_lanes;
    logic [4:0]         round_q, round_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               zero_pend_q, zero_pend_d;
    logic               done_q, done_d;
    logic               out_ready_q, out_ready_d;
    logic [OUT_W-1:0]   out_rng_q, out_rng_d;

    keccak_f200_round u_round (
        .state      (state_q),
        .round      (round_q),
        .state_next (round_out)
    );

    // Seed byte b lands in lane b (byte order reversed into lane order).
    always_comb begin
        seed_lanes = '0;
        for (int b = 0; b < SEED_W/8; b++)
            seed_lanes[STATE_W-1-8*b -: 8] = bus.in_seed[8*b +: 8];
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        round_d     = round_q;
        k_d         = k_q;
        remaining_d = remaining_q;
        zero_pend_d = 1'b0;
        done_d      = zero_pend_q;   // zero-length request completes a cycle late

        case (fsm_q)
            ST_IDLE: begin
                if (bus.in_ready) begin
                    state_d     = bus.in_mod ? seed_lanes : '0;
                    remaining_d = bus.in_nwords;
                    round_d     = '0;
                    k_d         = '0;
                    if (bus.in_nwords == '0) zero_pend_d = 1'b1;
                    else                     fsm_d       = ST_PERMUTE;
                end
            end
            ST_PERMUTE: begin
                state_d = round_out;
                if (round_q == LAST_ROUND) begin
                    round_d = '0;
                    k_d     = '0;
                    fsm_d   = ST_SQUEEZE;
                end else begin
                    round_d = round_q + 5'd1;
                end
            end
            ST_SQUEEZE: begin
                if (bus.out_ack) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    k_d         = k_q + K_W'(1);
                    // Exit test on the pre-decrement value: remaining never wraps.
                    if (remaining_q == CNT_W'(1)) begin
                        fsm_d  = ST_IDLE;
                        done_d = 1'b1;
                    end else if (k_q == K_W'(WORDS - 1)) begin
                        fsm_d   = ST_PERMUTE;
                        round_d = '0;
                    end
                end
            end
            default: fsm_d = ST_IDLE;
        endcase

        // Outputs are registered from next-state so they line up with the FSM.
        out_ready_d = (fsm_d == ST_SQUEEZE);
        out_rng_d   = out_ready_d ? state_d[STATE_W-1-OUT_W*int'(k_d) -: OUT_W] : '0;
    end

    // NOTE: the sponge state is an ordinary register, not a RAM, so it is
    // cleared on reset; an aborted request leaves no seed material behind.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            round_q     <= '0;
            k_q         <= '0;
            remaining_q <= '0;
            zero_pend_q <= 1'b0;
            done_q      <= 1'b0;
            out_ready_q <= 1'b0;
            out_rng_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            round_q     <= round_d;
            k_q         <= k_d;
            remaining_q <= remaining_d;
            zero_pend_q <= zero_pend_d;
            done_q      <= done_d;
            out_ready_q <= out_ready_d;
            out_rng_q   <= out_rng_d;
        end
    end

    assign bus.busy      = (fsm_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.out_ready = out_ready_q;
    assign bus.out_rng   = out_rng_q;

endmodule

// File: tb/tb_prng_sponge.sv
// -----------------------------------------------------------------------------
// tb_prng_sponge
// Table-driven check of prng_sponge against a stand-alone Keccak-f[200]
// reference (round constants from the LFSR, rho offsets from the (x,y) walk),
// plus hand-written reset-abort sequences.
// -----------------------------------------------------------------------------
module tb_prng_sponge;

    logic clk = 1'b0;
    logic rst_b;

    always #5 clk = ~clk;

    prng_sponge_if #(.SEED_W(96), .OUT_W(32), .CNT_W(16)) bus ();

    prng_sponge #(.SEED_W(96), .RATE(96), .OUT_W(32), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
        if (n == 0) return v;
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic lfsr_bit(input int t);
        logic [8:0] r;
        r = 9'h001;
        for (int i = 0; i < t; i++) begin
            r = r << 1;
            if (r[8]) r = r ^ 9'h171;
        end
        return r[0];
    endfunction

    // Lane i of the packed array is lane 5y+x.
    function automatic logic [24:0][7:0] model_perm(input logic [24:0][7:0] s);
        logic [24:0][7:0] a, b;
        logic [4:0][7:0]  c;
        logic [7:0]       d, rc;
        int               off [25];
        int               x, y, tx;
        a = s;
        b = '0;
        off[0] = 0;
        x = 1; y = 0;
        for (int t = 0; t < 24; t++) begin
            off[x + 5*y] = ((t + 1) * (t + 2) / 2) % 8;
            tx = x; x = y; y = (2*tx + 3*y) % 5;
        end
        for (int r = 0; r < 18; r++) begin
            for (int i = 0; i < 5; i++) c[i] = a[i] ^ a[i+5] ^ a[i+10] ^ a[i+15] ^ a[i+20];
            for (int i = 0; i < 25; i++) begin
                d = c[(i%5 + 4) % 5] ^ rol8(c[(i%5 + 1) % 5], 1);
                a[i] = a[i] ^ d;
            end
            for (int i = 0; i < 25; i++) begin
                x = i % 5; y = i / 5;
                b[y + 5*((2*x + 3*y) % 5)] = rol8(a[i], off[i]);
            end
            for (int i = 0; i < 25; i++)
                a[i] = b[i] ^ (~b[(i/5)*5 + (i%5 + 1) % 5] & b[(i/5)*5 + (i%5 + 2) % 5]);
            rc = '0;
            for (int j = 0; j < 4; j++) rc[(1 << j) - 1] = lfsr_bit(j + 7*r);
            a[0] = a[0] ^ rc;
        end
        return a;
    endfunction

    // ---------------- vector table ----------------
    typedef struct packed {
        logic             mode;
        logic [95:0]      seed;
        logic [15:0]      nwords;
        logic [3:0]       stall_word;   // 15 = no stall
        logic [3:0]       stall_len;
        logic             poke;         // wiggle request inputs while busy
        logic [7:0][31:0] exp_word;
        logic [7:0][15:0] exp_cycle;
        logic [15:0]      exp_done;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs [NVEC];

    // Word j appears in cycle 18 + 21*(j/3) + j%3, pushed out by any stall
    // on an earlier word; done follows the final ack.
    task automatic fill(input int i);
        logic [24:0][7:0] s;
        int n, sw, sl;
        s = '0;
        if (vecs[i].mode) for (int b = 0; b < 12; b++) s[b] = vecs[i].seed[8*b +: 8];
        n  = int'(vecs[i].nwords);
        sw = int'(vecs[i].stall_word);
        sl = int'(vecs[i].stall_len);
        for (int j = 0; j < n && j < 8; j++) begin
            if (j % 3 == 0) s = model_perm(s);
            vecs[i].exp_word[j]  = {s[4*(j%3)], s[4*(j%3)+1], s[4*(j%3)+2], s[4*(j%3)+3]};
            vecs[i].exp_cycle[j] = 16'(18 + (j/3)*21 + j%3 + ((sw != 15 && j > sw) ? sl : 0));
        end
        if (n == 0) vecs[i].exp_done = 16'd1;
        else        vecs[i].exp_done = 16'(int'(vecs[i].exp_cycle[n-1]) + 1 + ((sw == n-1) ? sl : 0));
    endtask

    // Starts at a falling edge; the next rising edge is the accepting edge 0.
    // Returns at the falling edge of the done cycle so the next request can
    // be accepted back-to-back.
    task automatic run_vec(input int i);
        vec_t v;
        int   widx, seen, stalled, done_cyc, spur, busy_bad;
        v = vecs[i];
        bus.in_ready  = 1'b1;
        bus.in_seed   = v.seed;
        bus.in_mod    = v.mode;
        bus.in_nwords = v.nwords;
        bus.out_ack   = 1'b1;
        @(negedge clk);
        bus.in_ready = 1'b0;
        widx = 0; seen = -1; stalled = 0; done_cyc = -1; spur = 0; busy_bad = 0;
        for (int c = 0; c < 400; c++) begin
            if (bus.busy !== ((v.nwords != 0) && (c < int'(v.exp_done)))) busy_bad++;
            if (bus.out_ready === 1'b1) begin
                if (widx >= int'(v.nwords) || widx >= 8) begin
                    spur++;
                end else begin
                    if (widx != seen) begin
                        check($sformatf("v%0d word%0d cycle", i, widx), c, v.exp_cycle[widx]);
                        seen = widx;
                    end
                    check($sformatf("v%0d word%0d c%0d value", i, widx, c), bus.out_rng, v.exp_word[widx]);
                    if (widx == int'(v.stall_word) && stalled < int'(v.stall_len)) begin
                        bus.out_ack = 1'b0;
                        stalled++;
                    end else begin
                        bus.out_ack = 1'b1;
                        widx++;
                    end
                end
            end else begin
                bus.out_ack = 1'b1;
            end
            if (bus.done === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (v.poke) begin
                bus.in_ready  = 1'($urandom_range(0, 1));
                bus.in_seed   = {$urandom, $urandom, $urandom};
                bus.in_mod    = 1'($urandom_range(0, 1));
                bus.in_nwords = 16'($urandom_range(0, 9));
            end
            @(negedge clk);
        end
        bus.in_ready = 1'b0;
        bus.out_ack  = 1'b1;
        check($sformatf("v%0d done cycle", i), done_cyc, v.exp_done);
        check($sformatf("v%0d words taken", i), widx, v.nwords);
        check($sformatf("v%0d stray out_ready", i), spur, 0);
        check($sformatf("v%0d busy profile", i), busy_bad, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [24:0][7:0] ref_s;
        int busy_seen, done_seen, rdy_seen;

        rst_b         = 1'b0;
        bus.in_ready  = 1'b0;
        bus.in_seed   = '0;
        bus.in_mod    = 1'b0;
        bus.in_nwords = '0;
        bus.out_ack   = 1'b1;

        vecs[0] = '{mode: 1'b0, seed: 96'hdeadbeef_cafef00d_12345678, nwords: 16'd3,
                    stall_word: 4'd15, stall_len: 4'd0, poke: 1'b0,
                    exp_word: '0, exp_cycle: '0, exp_done: '0};
        vecs[1] = '{mode: 1'b1, seed: 96'h000102030405060708090a0b, nwords: 16'd7,
                    stall_word: 4'd15, stall_len: 4'd0, poke: 1'b0,
                    exp_word: '0, exp_cycle: '0, exp_done: '0};
        vecs[2] = '{mode: 1'b1, seed: 96'h000102030405060708090a0b, nwords: 16'd7,
                    stall_word: 4'd1, stall_len: 4'd5, poke: 1'b0,
                    exp_word: '0, exp_cycle: '0, exp_done: '0};
        vecs[3] = '{mode: 1'b1, seed: 96'h555555555555555555555555, nwords: 16'd0,
                    stall_word: 4'd15, stall_len: 4'd0, poke: 1'b0,
                    exp_word: '0, exp_cycle: '0, exp_done: '0};
        vecs[4] = '{mode: 1'b1, seed: 96'h0123456789abcdeffedcba98, nwords: 16'd4,
                    stall_word: 4'd15, stall_len: 4'd0, poke: 1'b1,
                    exp_word: '0, exp_cycle: '0, exp_done: '0};
        vecs[5] = '{mode: 1'b1, seed: 96'hffffffffffffffffffffffff, nwords: 16'd6,
                    stall_word: 4'd2, stall_len: 4'd3, poke: 1'b0,
                    exp_word: '0, exp_cycle: '0, exp_done: '0};
        for (int i = 0; i < NVEC; i++) fill(i);

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset out_ready", bus.out_ready, 0);
        check("reset out_rng", bus.out_rng, 0);
        rst_b = 1'b1;
        @(negedge clk);

        // Abort in PERMUTE at round 7
        bus.in_ready = 1'b1; bus.in_mod = 1'b1; bus.in_nwords = 16'd5;
        bus.in_seed  = 96'h000102030405060708090a0b;
        @(negedge clk);
        bus.in_ready = 1'b0;
        repeat (7) @(negedge clk);
        check("abort permute busy before", bus.busy, 1);
        rst_b = 1'b0;
        #1;
        check("abort permute busy", bus.busy, 0);
        check("abort permute done", bus.done, 0);
        check("abort permute out_ready", bus.out_ready, 0);
        check("abort permute out_rng", bus.out_rng, 0);
        @(negedge clk);
        rst_b = 1'b1;
        busy_seen = 0; done_seen = 0; rdy_seen = 0;
        repeat (25) begin
            @(negedge clk);
            busy_seen += int'(bus.busy);
            done_seen += int'(bus.done);
            rdy_seen  += int'(bus.out_ready);
        end
        check("post-abort busy cycles", busy_seen, 0);
        check("post-abort done cycles", done_seen, 0);
        check("post-abort ready cycles", rdy_seen, 0);

        // Abort in SQUEEZE while the first word is held
        ref_s = '0;
        for (int b = 0; b < 12; b++) ref_s[b] = vecs[1].seed[8*b +: 8];
        ref_s = model_perm(ref_s);
        bus.in_ready = 1'b1; bus.out_ack = 1'b0;
        @(negedge clk);
        bus.in_ready = 1'b0;
        repeat (18) @(negedge clk);
        check("abort squeeze ready before", bus.out_ready, 1);
        check("abort squeeze word before", bus.out_rng, {ref_s[0], ref_s[1], ref_s[2], ref_s[3]});
        rst_b = 1'b0;
        #1;
        check("abort squeeze out_ready", bus.out_ready, 0);
        check("abort squeeze out_rng", bus.out_rng, 0);
        check("abort squeeze busy", bus.busy, 0);
        @(negedge clk);
        rst_b = 1'b1;
        bus.out_ack = 1'b1;
        repeat (2) @(negedge clk);
        check("post-squeeze-abort done", bus.done, 0);

        // Table vectors, issued back-to-back
        for (int i = 0; i < NVEC; i++) run_vec(i);
        repeat (2) @(negedge clk);
        check("final idle busy", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, expected completion");
        $fatal(1);
    end

endmodule
